// File: rtl/eth_tx_frame_gen_if.sv
// AXI-Stream style TX beat bus between the frame generator and the MAC.
// master drives tdata/tkeep/tuser/tlast/tvalid; slave drives tready.
interface eth_tx_frame_gen_if;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic [31:0] tuser;
   logic        tlast;
   logic        tvalid;
   logic        tready;

   modport master (
      output tdata, tkeep, tuser, tlast, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tuser, tlast, tvalid,
      output tready
   );
endinterface

// File: rtl/eth_tx_frame_gen.sv
// Ethernet TX frame generator: header + incrementing payload, 8 bytes/beat.
// Ports: i_xgmii_clk/i_xgmii_rst, i_start + frame fields in, m_axis beats
// out, o_busy (SEND/GAP), o_done (one-cycle pulse after the last beat).
module eth_tx_frame_gen #(
   parameter int P_IFG_CYCLES  = 2,
   parameter int P_MIN_PAYLOAD = 46,
   parameter int P_MAX_PAYLOAD = 1500
) (
   input  logic                      i_xgmii_clk,
   input  logic                      i_xgmii_rst,
   input  logic                      i_start,
   input  logic [47:0]               i_dst_mac,
   input  logic [47:0]               i_src_mac,
   input  logic [15:0]               i_eth_type,
   input  logic [15:0]               i_payload_len,
   input  logic [7:0]                i_seed,
   eth_tx_frame_gen_if.master        m_axis,
   output logic                      o_busy,
   output logic                      o_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP
   } state_t;

   state_t        r_state;
   logic [111:0]  r_hdr;
   logic [7:0]    r_seed;
   logic [15:0]   r_len;
   logic [7:0]    r_beat;
   logic [7:0]    r_last_beat;
   logic [15:0]   r_gap;

   logic [15:0]   w_pay;
   logic [15:0]   w_n;
   logic [15:0]   w_nbeats;
   logic [7:0]    w_last_beat;
   logic [71:0]   w_acc;
   logic [71:0]   w_nxt;

   // Build beat number 'beat' of a frame of n bytes: {tkeep, tdata}.
   // Lanes past the frame end stay zero with keep cleared.
   function automatic logic [71:0] f_beat(
      input logic [7:0]   beat,
      input logic [111:0] hdr,
      input logic [7:0]   seed,
      input logic [15:0]  n
   );
      logic [63:0] d;
      logic [7:0]  k8;
      logic [15:0] p;
      d  = '0;
      k8 = '0;
      for (int k = 0; k < 8; k++) begin
         p = {5'd0, beat, 3'd0} + 16'(k);
         if (p < n) begin
            k8[k] = 1'b1;
            if (p < 16'd14)
               d[8*k +: 8] = hdr[8*(13 - int'(p)) +: 8];
            else
               d[8*k +: 8] = seed + p[7:0] - 8'd14;
         end
      end
      return {k8, d};
   endfunction

   always_comb begin
      w_pay = i_payload_len;
      if (i_payload_len < 16'(P_MIN_PAYLOAD))
         w_pay = 16'(P_MIN_PAYLOAD);
      else if (i_payload_len > 16'(P_MAX_PAYLOAD))
         w_pay = 16'(P_MAX_PAYLOAD);
   end

   assign w_n         = w_pay + 16'd14;
   assign w_nbeats    = (w_n + 16'd7) >> 3;
   assign w_last_beat = 8'(w_nbeats - 16'd1);

   // Beat 0 is built straight from the inputs so it is ready in t+1.
   assign w_acc = f_beat(8'd0, {i_dst_mac, i_src_mac, i_eth_type},
                         i_seed, w_n);
   assign w_nxt = f_beat(r_beat + 8'd1, r_hdr, r_seed, r_len);

   always_ff @(posedge i_xgmii_clk) begin
      if (i_xgmii_rst) begin
         r_state       <= S_IDLE;
         r_hdr         <= '0;
         r_seed        <= '0;
         r_len         <= '0;
         r_beat        <= '0;
         r_last_beat   <= '0;
         r_gap         <= '0;
         m_axis.tdata  <= '0;
         m_axis.tkeep  <= '0;
         m_axis.tuser  <= '0;
         m_axis.tlast  <= 1'b0;
         m_axis.tvalid <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
      end else begin
         o_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state       <= S_SEND;
                  r_hdr         <= {i_dst_mac, i_src_mac, i_eth_type};
                  r_seed        <= i_seed;
                  r_len         <= w_n;
                  r_beat        <= 8'd0;
                  r_last_beat   <= w_last_beat;
                  m_axis.tdata  <= w_acc[63:0];
                  m_axis.tkeep  <= w_acc[71:64];
                  m_axis.tuser  <= {16'd0, w_n};
                  m_axis.tlast  <= (w_last_beat == 8'd0);
                  m_axis.tvalid <= 1'b1;
                  o_busy        <= 1'b1;
               end
            end
            S_SEND: begin
               if (m_axis.tvalid && m_axis.tready) begin
                  if (m_axis.tlast) begin
                     m_axis.tdata  <= '0;
                     m_axis.tkeep  <= '0;
                     m_axis.tuser  <= '0;
                     m_axis.tlast  <= 1'b0;
                     m_axis.tvalid <= 1'b0;
                     o_done        <= 1'b1;
                     if (P_IFG_CYCLES == 0) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                     end else begin
                        r_state <= S_GAP;
                        r_gap   <= 16'(P_IFG_CYCLES - 1);
                     end
                  end else begin
                     r_beat       <= r_beat + 8'd1;
                     m_axis.tdata <= w_nxt[63:0];
                     m_axis.tkeep <= w_nxt[71:64];
                     m_axis.tlast <= (r_beat + 8'd1 == r_last_beat);
                  end
               end
            end
            S_GAP: begin
               // The o_done cycle is the first of the gap cycles.
               if (r_gap == 16'd0) begin
                  r_state <= S_IDLE;
                  o_busy  <= 1'b0;
               end else begin
                  r_gap <= r_gap - 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_frame_gen.sv
// Scoreboard bench for eth_tx_frame_gen: directed frames, stalls, reset.
// Expected beats are queued at issue time; a negedge monitor checks them.
module tb_eth_tx_frame_gen;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic [31:0] u;
      logic        l;
   } beat_t;

   typedef struct packed {
      logic [15:0] nb;
      logic [7:0]  kl;
   } fr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [47:0] dst = '0;
   logic [47:0] src = '0;
   logic [15:0] typ = '0;
   logic [15:0] len = '0;
   logic [7:0]  seed = '0;
   logic        busy;
   logic        done;
   bit          rnd = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int frame_cnt = 0;
   int exp_done = 0;

   beat_t bq[$];
   fr_t   fq[$];

   eth_tx_frame_gen_if axis ();

   eth_tx_frame_gen dut (
      .i_xgmii_clk   (clk),
      .i_xgmii_rst   (rst),
      .i_start       (start),
      .i_dst_mac     (dst),
      .i_src_mac     (src),
      .i_eth_type    (typ),
      .i_payload_len (len),
      .i_seed        (seed),
      .m_axis        (axis),
      .o_busy        (busy),
      .o_done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // Expected frame from the byte-order rules; n/nb/kl are hand values.
   task automatic push_frame(input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] t, input logic [7:0] sd,
                             input int n, input int nb,
                             input logic [7:0] kl);
      logic [7:0] fb[$];
      beat_t x;
      fr_t f;
      int p;
      for (int i = 0; i < 6; i++) fb.push_back(d[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) fb.push_back(s[47-8*i -: 8]);
      fb.push_back(t[15:8]);
      fb.push_back(t[7:0]);
      for (int i = 0; i < n - 14; i++) fb.push_back(sd + 8'(i));
      for (int b = 0; b < (n + 7) / 8; b++) begin
         x = '0;
         for (int ln = 0; ln < 8; ln++) begin
            p = b * 8 + ln;
            if (p < n) begin
               x.k[ln] = 1'b1;
               x.d[8*ln +: 8] = fb[p];
            end
         end
         x.u = 32'(n);
         x.l = (b == (n + 7) / 8 - 1);
         bq.push_back(x);
      end
      f.nb = 16'(nb);
      f.kl = kl;
      fq.push_back(f);
   endtask

   // tready driver: constant 1, or 50% random when rnd is set.
   initial begin
      axis.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: checks transferred beats, stall stability, frame totals.
   initial begin
      beat_t cur, held;
      fr_t f;
      bit stall = 1'b0;
      int cb = 0;
      held = '0;
      forever begin
         @(negedge clk);
         cur = {axis.tdata, axis.tkeep, axis.tuser, axis.tlast};
         if (stall) begin
            chk("stall_hold", {cur, axis.tvalid}, {held, 1'b1});
         end
         if (axis.tvalid && axis.tready) begin
            if (bq.size() == 0) begin
               chk("unexpected_beat", 1'b1, 1'b0);
            end else begin
               chk("beat", cur, bq.pop_front());
            end
            cb++;
            if (axis.tlast) begin
               frame_cnt++;
               if (fq.size() != 0) begin
                  f = fq.pop_front();
                  chk("frame_beats", 128'(cb), 128'(f.nb));
                  chk("last_keep", axis.tkeep, f.kl);
               end
               cb = 0;
            end
         end
         stall = axis.tvalid && !axis.tready;
         held = cur;
         if (rst) begin
            bq.delete();
            fq.delete();
            cb = 0;
            stall = 1'b0;
         end
      end
   end

   task automatic wait_idle();
      int w = 0;
      while (busy && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (busy) chk("idle_timeout", busy, 1'b0);
   endtask

   task automatic wait_frames();
      int w = 0;
      while (frame_cnt < exp_done && w < 5000) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (frame_cnt < exp_done)
         chk("frame_timeout", 128'(frame_cnt), 128'(exp_done));
   endtask

   task automatic send(input logic [47:0] d, input logic [47:0] s,
                       input logic [15:0] t, input logic [15:0] l,
                       input logic [7:0] sd, input int n, input int nb,
                       input logic [7:0] kl);
      wait_idle();
      dst = d;
      src = s;
      typ = t;
      len = l;
      seed = sd;
      push_frame(d, s, t, sd, n, nb, kl);
      exp_done++;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("latency", axis.tvalid, 1'b1);
      wait_frames();
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {axis.tvalid, axis.tlast}, 2'b00);
      chk("rst_bus", {axis.tdata, axis.tkeep, axis.tuser}, '0);
      chk("rst_busy", {busy, done}, 2'b00);

      // Start in the same cycle as reset must be ignored.
      start = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("start_in_rst", {axis.tvalid, busy}, 2'b00);

      // Frame A: minimum frame, start held through SEND and GAP.
      dst = 48'h0011_2233_4455;
      src = 48'h6677_8899_AABB;
      typ = 16'h0800;
      len = 16'd46;
      seed = 8'h00;
      push_frame(dst, src, typ, seed, 60, 8, 8'h0F);
      exp_done++;
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("lat_A", {axis.tvalid, busy}, 2'b11);
      // Change inputs in flight; these become frame B later.
      dst = 48'hA1A2_A3A4_A5A6;
      src = 48'hB1B2_B3B4_B5B6;
      typ = 16'h88B5;
      len = 16'd50;
      seed = 8'hFE;
      push_frame(dst, src, typ, seed, 64, 8, 8'hFF);
      exp_done++;
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      chk("tlast_A", {axis.tvalid, axis.tlast, axis.tkeep}, {2'b11, 8'h0F});
      chk("tuser_A", axis.tuser, 32'd60);
      @(posedge clk);
      #1;
      chk("done_A", {axis.tvalid, done, busy}, 3'b011);
      @(posedge clk);
      #1;
      chk("gap2_A", {axis.tvalid, done, busy}, 3'b001);
      @(posedge clk);
      #1;
      chk("idle_A", {axis.tvalid, busy}, 2'b00);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("acc_B", {axis.tvalid, axis.tdata[7:0]}, {1'b1, 8'hA1});
      @(posedge clk);
      #1;
      chk("b14_B", axis.tdata[63:48], 16'hFFFE);
      wait_frames();

      send(48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 16'h86DD,
           16'd10, 8'h10, 60, 8, 8'h0F);
      send(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0806,
           16'd2000, 8'h80, 1514, 190, 8'h03);

      rnd = 1'b1;
      send(48'h1234_5678_9ABC, 48'hDEF0_1234_5678, 16'h1234,
           16'd100, 8'h05, 114, 15, 8'h03);
      send(48'hCAFE_BABE_0001, 48'hFEED_FACE_0002, 16'h0800,
           16'd1000, 8'hC0, 1014, 127, 8'h3F);
      rnd = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end

      // Reset while beat 3 is on the bus.
      wait_idle();
      dst = 48'h5555_5555_5555;
      src = 48'hAAAA_AAAA_AAAA;
      typ = 16'h0800;
      len = 16'd46;
      seed = 8'h40;
      push_frame(dst, src, typ, seed, 60, 8, 8'h0F);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("beat3", {axis.tvalid, axis.tlast}, 2'b10);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid", {axis.tvalid, axis.tlast, done, busy, axis.tkeep},
          '0);
      rst = 1'b0;
      send(48'h0000_0000_0001, 48'h0000_0000_0002, 16'h0801,
           16'd46, 8'h33, 60, 8, 8'h0F);
      chk("frame_count", 128'(frame_cnt), 128'(exp_done));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/eth_tx_frame_gen.md
ETH_TX_FRAME_GEN -- requirements
Module: eth_tx_frame_gen

Interface
REQ-001 SHALL have parameter P_IFG_CYCLES, default 2, meaning the number of idle cycles enforced after each frame's last beat.
REQ-002 SHALL have parameter P_MIN_PAYLOAD, default 46, meaning the minimum payload byte count; shorter requests are padded up to it.
REQ-003 SHALL have parameter P_MAX_PAYLOAD, default 1500, meaning the maximum payload byte count; longer requests are truncated to it.
REQ-004 Ports, clock and reset first: i_xgmii_clk  in  1  the single clock; all logic is synchronous to it.
REQ-005 i_xgmii_rst  in  1  reset, synchronous, active-high.
REQ-006 i_start  in  1  frame request, sampled in IDLE only.
REQ-007 i_dst_mac  in  48  destination MAC, captured on accept.
REQ-008 i_src_mac  in  48  source MAC, captured on accept.
REQ-009 i_eth_type  in  16  EtherType, captured on accept.
REQ-010 i_payload_len  in  16  requested payload byte count, captured on accept.
REQ-011 i_seed  in  8  first payload byte value, captured on accept.
REQ-012 m_axis_tdata  out  64  frame bytes; byte k of a beat is on bits [8k+7:8k], and byte 0 goes first on the wire.
REQ-013 m_axis_tkeep  out  8  byte-valid mask, contiguous from bit 0.
REQ-014 m_axis_tuser  out  32  bits [15:0] carry the frame byte count N; bits [31:16] are 0.
REQ-015 m_axis_tlast  out  1  marks the last beat of a frame.
REQ-016 m_axis_tvalid  out  1  beat valid.
REQ-017 m_axis_tready  in  1  downstream ready (MAC TX input).
REQ-018 o_busy  out  1  high in SEND and GAP.
REQ-019 o_done  out  1  one-cycle pulse when a frame completes.

Function
REQ-020 The effective payload length L SHALL be i_payload_len clamped to the range [P_MIN_PAYLOAD, P_MAX_PAYLOAD]; frame length N = 14 + L.
REQ-021 Frame byte order SHALL be:
- bytes 0-5: dst MAC, bits [47:40] first;
- bytes 6-11: src MAC, bits [47:40] first;
- bytes 12-13: EtherType, bits [15:8] first;
- byte 14+k: payload byte (i_seed + k) mod 256.
REQ-022 Beat count SHALL be ceil(N/8); all beats except the last SHALL have tkeep = 0xFF.
REQ-023 Last beat tkeep SHALL be 0xFF when N mod 8 = 0, otherwise (1 << (N mod 8)) - 1; tdata bytes with tkeep=0 SHALL be 0.
REQ-024 State machine states SHALL be IDLE, SEND and GAP.
REQ-025 IDLE -> SEND when i_start=1; the inputs of REQ-007..REQ-011 are captured in that same cycle.
REQ-026 Latency: a start accepted in cycle t SHALL produce tvalid=1 with beat 0 in cycle t+1.
REQ-027 Handshake: a beat transfers when tvalid and tready are both 1; while tvalid=1 and tready=0, tdata/tkeep/tuser/tlast SHALL hold stable.
REQ-028 tvalid SHALL stay high from beat 0 until the last beat transfers, with no bubbles inserted by this block.
REQ-029 SEND -> GAP on the last-beat transfer; tvalid=0 and o_done=1 in the following cycle.
REQ-030 GAP SHALL last exactly P_IFG_CYCLES cycles, counted from the o_done cycle, then go to IDLE.
REQ-031 P_IFG_CYCLES=0 SHALL go directly SEND -> IDLE.
REQ-032 i_start SHALL be ignored in SEND and GAP, with no queueing.
REQ-033 Input changes after accept SHALL NOT affect the frame in flight.
REQ-034 The beat counter SHALL be 8 bits, sufficient for max 190 beats (N = 1514); the payload byte counter SHALL wrap mod 256.

Reset
REQ-035 On i_xgmii_rst=1 at a clock edge, the state SHALL go to IDLE and all outputs SHALL be 0 (tdata, tkeep, tuser, tlast, tvalid, o_busy, o_done) in the next cycle.
REQ-036 Reset mid-frame SHALL drop tvalid without asserting tlast; no partial frame resumes after reset.
REQ-037 i_start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-038 L=46, tready=1 -> N=60, 8 beats in consecutive cycles, last tkeep=0x0F, tuser=60, o_done one cycle after last, o_busy low after 2 GAP cycles.
REQ-039 L=50, seed=0xFE -> N=64, 8 beats, last tkeep=0xFF; payload bytes FE, FF, 00, 01, ..., with byte 14 at beat 1 lane 6.
REQ-040 i_payload_len=10 -> L=46, N=60; i_payload_len=2000 -> L=1500, N=1514, 190 beats, last tkeep=0x03.
REQ-041 Random tready (50%) -> beat content held stable during stalls; received byte stream equals the frame of REQ-021.
REQ-042 i_start pulsed during SEND and during GAP -> no second frame; a start on the first IDLE cycle is accepted.
REQ-043 Reset asserted at beat 3 -> tvalid=0 next cycle, no tlast, o_done=0; the next start produces a complete frame from beat 0.
